// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, functs,
// ALU control codes and datapath select codes.
package mips_ctrl_pkg;

  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_MEMADR  = 4'd2;
  localparam logic [3:0] ST_MEMRD   = 4'd3;
  localparam logic [3:0] ST_MEMWB   = 4'd4;
  localparam logic [3:0] ST_MEMWR   = 4'd5;
  localparam logic [3:0] ST_RTYPEEX = 4'd6;
  localparam logic [3:0] ST_RTYPEWB = 4'd7;
  localparam logic [3:0] ST_BEQEX   = 4'd8;
  localparam logic [3:0] ST_ADDIEX  = 4'd9;
  localparam logic [3:0] ST_ADDIWB  = 4'd10;
  localparam logic [3:0] ST_JEX     = 4'd11;

  typedef enum logic [3:0] {
    FETCH   = ST_FETCH,
    DECODE  = ST_DECODE,
    MEMADR  = ST_MEMADR,
    MEMRD   = ST_MEMRD,
    MEMWB   = ST_MEMWB,
    MEMWR   = ST_MEMWR,
    RTYPEEX = ST_RTYPEEX,
    RTYPEWB = ST_RTYPEWB,
    BEQEX   = ST_BEQEX,
    ADDIEX  = ST_ADDIEX,
    ADDIWB  = ST_ADDIWB,
    JEX     = ST_JEX
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // alu_op from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control-unit <-> datapath bundle: instruction/flag inputs to the FSM and
// the selects/strobes it drives back. master = control unit, slave = datapath.
interface multicycle_main_fsm_if #(
  parameter int ALUCTL_W = 3
);
  logic [5:0]          op;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  logic                mem_write;
  logic                ir_write;
  logic                reg_write;
  logic                pc_en;
  logic                iord;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          pc_src;
  logic [ALUCTL_W-1:0] alu_control;
  logic                illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_write, ir_write, reg_write, pc_en, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, pc_src, alu_control, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_write, ir_write, reg_write, pc_en, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, pc_src, alu_control, illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// ALU control decode from the FSM's alu_op and the instruction funct field.
// Latency: purely combinational. Backpressure: none.
// Unknown functs fall back to add and raise funct_illegal.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct)
          FN_ADD: alu_control = ALU_ADD;
          FN_SUB: alu_control = ALU_SUB;
          FN_AND: alu_control = ALU_AND;
          FN_OR:  alu_control = ALU_OR;
          FN_SLT: alu_control = ALU_SLT;
          default: begin
            alu_control   = ALU_ADD;
            funct_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for a shared-memory multicycle MIPS datapath.
// Latency: outputs decoded combinationally from the current state; one state per cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready (when WAIT_ON_MEM=1).
module multicycle_main_fsm
  import mips_ctrl_pkg::*;
#(
  parameter bit WAIT_ON_MEM = 1'b1,
  parameter int ALUCTL_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_main_fsm_if.master bus
);

  state_t     state, state_nxt;
  logic       mem_rdy;
  logic       mem_write_d, ir_write_d, reg_write_d;
  logic       pc_write, branch, op_illegal;
  logic       iord_d, mem_to_reg_d, reg_dst_d, alu_src_a_d;
  logic [1:0] alu_src_b_d, pc_src_d, alu_op;
  logic [2:0] alu_ctl;
  logic       funct_illegal;

  assign mem_rdy = WAIT_ON_MEM ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mem_write_d  = 1'b0;
    ir_write_d   = 1'b0;
    reg_write_d  = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    op_illegal   = 1'b0;
    iord_d       = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_dst_d    = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = SRCB_B;
    pc_src_d     = PCSRC_ALU;
    alu_op       = ALUOP_ADD;
    case (state)
      FETCH: begin
        alu_src_b_d = SRCB_FOUR;
        ir_write_d  = mem_rdy;
        pc_write    = mem_rdy;
        if (mem_rdy) state_nxt = DECODE;
      end
      DECODE: begin
        // Branch target precomputed here so BEQEX can select ALUOut.
        alu_src_b_d = SRCB_IMM_SH;
        case (bus.op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = RTYPEEX;
          OP_BEQ:       state_nxt = BEQEX;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JEX;
          default: begin
            op_illegal = 1'b1;
            state_nxt  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = SRCB_IMM;
        state_nxt   = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord_d = 1'b1;
        if (mem_rdy) state_nxt = MEMWB;
      end
      MEMWB: begin
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
        state_nxt    = FETCH;
      end
      MEMWR: begin
        iord_d      = 1'b1;
        mem_write_d = 1'b1;
        if (mem_rdy) state_nxt = FETCH;
      end
      RTYPEEX: begin
        alu_src_a_d = 1'b1;
        alu_op      = ALUOP_FUNCT;
        state_nxt   = RTYPEWB;
      end
      RTYPEWB: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
        state_nxt   = FETCH;
      end
      BEQEX: begin
        alu_src_a_d = 1'b1;
        alu_op      = ALUOP_SUB;
        pc_src_d    = PCSRC_ALUOUT;
        branch      = 1'b1;
        state_nxt   = FETCH;
      end
      ADDIEX: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = SRCB_IMM;
        state_nxt   = ADDIWB;
      end
      ADDIWB: begin
        reg_write_d = 1'b1;
        state_nxt   = FETCH;
      end
      JEX: begin
        pc_src_d  = PCSRC_JUMP;
        pc_write  = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .funct         (bus.funct),
    .alu_control   (alu_ctl),
    .funct_illegal (funct_illegal)
  );

  // Reset masks every output so an abandoned instruction cannot write anything.
  assign bus.mem_write   = ~reset & mem_write_d;
  assign bus.ir_write    = ~reset & ir_write_d;
  assign bus.reg_write   = ~reset & reg_write_d;
  assign bus.pc_en       = ~reset & (pc_write | (branch & bus.zero));
  assign bus.illegal     = ~reset & (op_illegal | funct_illegal);
  assign bus.iord        = ~reset & iord_d;
  assign bus.mem_to_reg  = ~reset & mem_to_reg_d;
  assign bus.reg_dst     = ~reset & reg_dst_d;
  assign bus.alu_src_a   = ~reset & alu_src_a_d;
  assign bus.alu_src_b   = reset ? 2'b00 : alu_src_b_d;
  assign bus.pc_src      = reset ? 2'b00 : pc_src_d;
  assign bus.alu_control = reset ? '0 : ALUCTL_W'(alu_ctl);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Randomized scoreboard bench: driver pushes per-cycle expected control words
// from an instruction-level model; a negedge monitor pops and compares.
module tb_multicycle_main_fsm;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

  typedef enum {T_RST, T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_RX, T_RWB,
                T_BX, T_AX, T_AWB, T_JX} step_e;

  typedef struct packed {
    logic       mem_write, ir_write, reg_write, pc_en;
    logic       iord, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       illegal;
  } ctl_t;

  typedef struct {
    step_e s;
    ctl_t  c;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t expq[$];

  always #5 clk = ~clk;

  multicycle_main_fsm_if #(.ALUCTL_W(3)) bus();

  multicycle_main_fsm #(.WAIT_ON_MEM(1'b1), .ALUCTL_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, ADDI, J};
  endfunction

  // {alu_control, illegal} for an R-type funct
  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return {3'b010, 1'b0};
      6'b100010: return {3'b110, 1'b0};
      6'b100100: return {3'b000, 1'b0};
      6'b100101: return {3'b001, 1'b0};
      6'b101010: return {3'b111, 1'b0};
      default:   return {3'b010, 1'b1};
    endcase
  endfunction

  function automatic ctl_t expect_ctl(input step_e s, input logic mr, input logic z,
                                      input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    c.alu_control = 3'b010;
    case (s)
      T_RST: c = '0;
      T_F:   begin c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_en = mr; end
      T_D:   begin c.alu_src_b = 2'b11; c.illegal = !legal_op(op); end
      T_MA:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      T_MR:  c.iord = 1'b1;
      T_MWB: begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      T_MW:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
      T_RX:  begin c.alu_src_a = 1'b1; {c.alu_control, c.illegal} = r_alu(fn); end
      T_RWB: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      T_BX:  begin c.alu_src_a = 1'b1; c.alu_control = 3'b110; c.pc_src = 2'b01; c.pc_en = z; end
      T_AX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      T_AWB: c.reg_write = 1'b1;
      T_JX:  begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic drive(input logic r, input logic mr, input logic z,
                       input logic [5:0] op, input logic [5:0] fn, input step_e s);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = r;
    bus.mem_ready = mr;
    bus.zero      = z;
    bus.op        = op;
    bus.funct     = fn;
    e.s = s;
    e.c = expect_ctl(s, mr, z, op, fn);
    expq.push_back(e);
  endtask

  // fix >= 0: FETCH never stalls, MEMRD/MEMWR stall exactly fix cycles.
  // zmode < 0: random zero each cycle. rst_at >= 0: reset on that cycle of the instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fix,
                           input int zmode, input int rst_at);
    step_e seq[$];
    int    cyc;
    seq = {T_F, T_D};
    case (op)
      LW:   seq = {seq, T_MA, T_MR, T_MWB};
      SW:   seq = {seq, T_MA, T_MW};
      RT:   seq = {seq, T_RX, T_RWB};
      BEQ:  seq = {seq, T_BX};
      ADDI: seq = {seq, T_AX, T_AWB};
      J:    seq = {seq, T_JX};
      default: ;
    endcase
    cyc = 0;
    foreach (seq[i]) begin
      int   st;
      logic done, mr, z, stall_step;
      st = 0;
      done = 1'b0;
      stall_step = seq[i] inside {T_F, T_MR, T_MW};
      while (!done) begin
        z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
        if (cyc == rst_at) begin
          drive(1'b1, 1'($urandom_range(0, 1)), z, op, fn, T_RST);
          return;
        end
        if (!stall_step)      mr = 1'($urandom_range(0, 1));
        else if (fix >= 0)    mr = (seq[i] == T_F) ? 1'b1 : (st >= fix);
        else                  mr = (st >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        drive(1'b0, mr, z, op, fn, seq[i]);
        cyc++;
        st++;
        done = !stall_step || mr;
      end
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      ctl_t a;
      e = expq.pop_front();
      a.mem_write   = bus.mem_write;
      a.ir_write    = bus.ir_write;
      a.reg_write   = bus.reg_write;
      a.pc_en       = bus.pc_en;
      a.iord        = bus.iord;
      a.mem_to_reg  = bus.mem_to_reg;
      a.reg_dst     = bus.reg_dst;
      a.alu_src_a   = bus.alu_src_a;
      a.alu_src_b   = bus.alu_src_b;
      a.pc_src      = bus.pc_src;
      a.alu_control = bus.alu_control;
      a.illegal     = bus.illegal;
      checks++;
      if (a !== e.c) begin
        errors++;
        $display("FAIL ctl_%s t=%0t: actual=%b required=%b (mw,irw,rw,pce,iord,m2r,rdst,srca,srcb,pcsrc,aluctl,ill)",
                 e.s.name(), $time, a, e.c);
      end
    end
  end

  initial begin
    bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 6'd0, 6'd0, T_RST);
    drive(1'b1, 1'b1, 1'b0, 6'd0, 6'd0, T_RST);
    run_instr(LW, 6'd0, 0, -1, -1);
    run_instr(SW, 6'd0, 3, -1, -1);
    run_instr(BEQ, 6'd0, 0, 1, -1);
    run_instr(BEQ, 6'd0, 0, 0, -1);
    run_instr(RT, 6'b101010, 0, -1, -1);
    run_instr(RT, 6'b111111, 0, -1, -1);
    run_instr(6'b111111, 6'd0, 0, -1, -1);
    run_instr(ADDI, 6'd0, 1, -1, -1);
    run_instr(J, 6'd0, 0, -1, -1);
    run_instr(SW, 6'd0, 5, -1, 5);
    run_instr(LW, 6'd0, 2, -1, 4);
    run_instr(ADDI, 6'd0, 0, -1, -1);
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, fn;
      logic [5:0] ops[7];
      logic [5:0] fns[5];
      ops = '{LW, SW, RT, BEQ, ADDI, J, 6'd0};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      ops[6] = 6'($urandom_range(0, 63));
      op = ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, -1, -1, ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 6)) : -1);
    end
    repeat (2) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d entries left required=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
